// File: rtl/cve2_pkg.sv
// Shared CSR read-modify-write types: access opcodes, sequencer states and
// the helper that computes a CSR's new value from its old value and operand.
package cve2_pkg;

  localparam int unsigned CsrMaxW = 64;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_rmw_op_e;

  typedef enum logic [2:0] {
    RMW_IDLE   = 3'd0,
    RMW_READ   = 3'd1,
    RMW_WRITE  = 3'd2,
    RMW_VERIFY = 3'd3,
    RMW_RESP   = 3'd4
  } csr_rmw_state_e;

  // Operands are zero-extended to CsrMaxW; callers keep the low bits they need.
  function automatic logic [CsrMaxW-1:0] csr_rmw_apply(
    input csr_rmw_op_e         op,
    input logic [CsrMaxW-1:0]  old_val,
    input logic [CsrMaxW-1:0]  operand
  );
    logic [CsrMaxW-1:0] res;
    case (op)
      CSR_OP_WRITE: res = operand;
      CSR_OP_SET:   res = old_val | operand;
      CSR_OP_CLEAR: res = old_val & ~operand;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cve2_csr_rmw_ctrl.sv
// CSR read-modify-write sequencer: reads the addressed CSR, writes the modified
// value once, optionally re-reads it to verify, and returns the old value.
module cve2_csr_rmw_ctrl
  import cve2_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned AddrWidth   = 12,
  parameter logic        VerifyWrite = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [1:0]           req_op_i,
  input  logic [Width-1:0]     req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [Width-1:0]     rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [AddrWidth-1:0] csr_addr_o,
  output logic [Width-1:0]     csr_wdata_o,
  output logic                 csr_we_o,
  input  logic [Width-1:0]     csr_rdata_i,
  input  logic                 csr_rd_error_i,
  output logic                 busy_o
);

  csr_rmw_state_e        state_q, state_d;
  csr_rmw_op_e           op_q, op_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [Width-1:0]      wdata_q, wdata_d;
  logic [Width-1:0]      old_q, old_d;
  logic [Width-1:0]      new_q, new_d;
  logic                  err_q, err_d;
  logic [CsrMaxW-1:0]    apply_full_s;
  logic                  skip_write_s;

  assign apply_full_s = csr_rmw_apply(op_q, CsrMaxW'(csr_rdata_i), CsrMaxW'(wdata_q));

  // SET/CLEAR with a zero operand cannot change the CSR, so no write is spent on it.
  assign skip_write_s = (op_q == CSR_OP_READ) || csr_rd_error_i ||
                        (((op_q == CSR_OP_SET) || (op_q == CSR_OP_CLEAR)) &&
                         (wdata_q == {Width{1'b0}}));

  // Sequencer state register and transaction data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RMW_IDLE;
      op_q    <= CSR_OP_READ;
      addr_q  <= {AddrWidth{1'b0}};
      wdata_q <= {Width{1'b0}};
      old_q   <= {Width{1'b0}};
      new_q   <= {Width{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      new_q   <= new_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    new_d   = new_q;
    err_d   = err_q;
    case (state_q)
      RMW_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          op_d    = csr_rmw_op_e'(req_op_i);
          wdata_d = req_wdata_i;
          err_d   = 1'b0;
          state_d = RMW_READ;
        end else begin
          state_d = RMW_IDLE;
        end
      end
      RMW_READ: begin
        old_d = csr_rdata_i;
        err_d = csr_rd_error_i;
        new_d = apply_full_s[Width-1:0];
        if (skip_write_s) begin
          state_d = RMW_RESP;
        end else begin
          state_d = RMW_WRITE;
        end
      end
      RMW_WRITE: begin
        if (VerifyWrite) begin
          state_d = RMW_VERIFY;
        end else begin
          state_d = RMW_RESP;
        end
      end
      RMW_VERIFY: begin
        err_d   = (csr_rdata_i != new_q) | csr_rd_error_i;
        state_d = RMW_RESP;
      end
      RMW_RESP: begin
        if (rsp_ready_i) begin
          state_d = RMW_IDLE;
        end else begin
          state_d = RMW_RESP;
        end
      end
      default: state_d = RMW_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == RMW_IDLE);
  assign rsp_valid_o = (state_q == RMW_RESP);
  assign rsp_rdata_o = rsp_valid_o ? old_q : {Width{1'b0}};
  assign rsp_error_o = rsp_valid_o & err_q;
  assign busy_o      = (state_q != RMW_IDLE);
  // Gated by reset so a reset landing in WRITE never commits the pending value.
  assign csr_we_o    = (state_q == RMW_WRITE) & rst_ni;
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = new_q;

endmodule

// File: tb/tb_cve2_csr_rmw_ctrl.sv
// Randomized bench for cve2_csr_rmw_ctrl against a small CSR bank and an
// abstract transaction-level model of what each access should do.
module tb_cve2_csr_rmw_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic [1:0]  req_op_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_we_o;
  logic [31:0] csr_rdata_i;
  logic        csr_rd_error_i;
  logic        busy_o;

  logic [31:0] mem [4];
  logic [31:0] exp_mem [4];
  logic        inject_err;
  logic        ignore_wr;
  int          we_cnt;
  logic [31:0] we_data;
  int          n_checks;
  int          n_fail;

  cve2_csr_rmw_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_op_i       (req_op_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_error_o    (rsp_error_o),
    .csr_addr_o     (csr_addr_o),
    .csr_wdata_o    (csr_wdata_o),
    .csr_we_o       (csr_we_o),
    .csr_rdata_i    (csr_rdata_i),
    .csr_rd_error_i (csr_rd_error_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_rdata_i    = mem[csr_addr_o[1:0]];
  assign csr_rd_error_i = inject_err;

  // Storage bank; a write can be suppressed to emulate a stuck CSR.
  always @(posedge clk) begin
    if (csr_we_o) begin
      we_cnt  = we_cnt + 1;
      we_data = csr_wdata_o;
      if (!ignore_wr) mem[csr_addr_o[1:0]] <= csr_wdata_o;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    mem[a]     = v;
    exp_mem[a] = v;
  endtask

  // One full access; expectations come from the access rules, not the sequencer.
  task automatic do_txn(input int a, input logic [1:0] op, input logic [31:0] wd,
                        input logic inj, input logic ign, input int hold);
    logic [31:0] old_v, new_v;
    logic        writes, exp_err;
    int          lat;
    old_v = exp_mem[a];
    case (op)
      2'd1:    new_v = wd;
      2'd2:    new_v = old_v | wd;
      2'd3:    new_v = old_v & ~wd;
      default: new_v = old_v;
    endcase
    writes  = !inj && (op != 2'd0) && !((op >= 2'd2) && (wd == 32'd0));
    exp_err = inj || (writes && ign && (new_v != old_v));
    if (writes && !ign) exp_mem[a] = new_v;

    inject_err  = inj;
    ignore_wr   = ign;
    we_cnt      = 0;
    check_val("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = 12'(a);
    req_op_i    = op;
    req_wdata_i = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_wdata_i = $urandom;
    lat = 1;
    while (!rsp_valid_o && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", 32'(lat), writes ? 32'd4 : 32'd2);
    check_val("rsp_rdata", rsp_rdata_o, old_v);
    check_val("rsp_error", {31'd0, rsp_error_o}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      check_val("hold_rdata", rsp_rdata_o, old_v);
      check_val("hold_error", {31'd0, rsp_error_o}, {31'd0, exp_err});
      check_val("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    check_val("rsp_done", {31'd0, rsp_valid_o}, 32'd0);
    check_val("idle_busy", {31'd0, busy_o}, 32'd0);
    check_val("we_count", 32'(we_cnt), writes ? 32'd1 : 32'd0);
    if (writes) check_val("we_data", we_data, new_v);
    check_val("csr_value", mem[a], exp_mem[a]);
    inject_err = 1'b0;
    ignore_wr  = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    we_cnt      = 0;
    we_data     = 32'd0;
    inject_err  = 1'b0;
    ignore_wr   = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = 12'd0;
    req_op_i    = 2'd0;
    req_wdata_i = 32'd0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) preload(i, 32'd0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check_val("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check_val("rst_rsp_error", {31'd0, rsp_error_o}, 32'd0);
    check_val("rst_we", {31'd0, csr_we_o}, 32'd0);
    check_val("rst_addr", {20'd0, csr_addr_o}, 32'd0);
    check_val("rst_wdata", csr_wdata_o, 32'd0);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    preload(1, 32'h0000_00F0);
    do_txn(1, 2'd2, 32'h0000_000F, 1'b0, 1'b0, 0);
    preload(2, 32'hFFFF_FFFF);
    do_txn(2, 2'd3, 32'h0000_FF00, 1'b0, 1'b0, 0);
    do_txn(2, 2'd3, 32'h0000_0000, 1'b0, 1'b0, 1);
    preload(3, 32'h1234_5678);
    do_txn(3, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5);
    do_txn(0, 2'd1, 32'hA5A5_A5A5, 1'b1, 1'b0, 0);
    preload(0, 32'h0000_0000);
    do_txn(0, 2'd1, 32'h0000_0001, 1'b0, 1'b1, 0);

    // Reset landing while the write pulse is up must kill the pulse.
    preload(1, 32'h0000_0011);
    we_cnt      = 0;
    req_valid_i = 1'b1;
    req_addr_i  = 12'd1;
    req_op_i    = 2'd1;
    req_wdata_i = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_we", {31'd0, csr_we_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_val("rst_in_write_we", {31'd0, csr_we_o}, 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    check_val("rst_in_write_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_in_write_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_val("rst_in_write_ready", {31'd0, req_ready_o}, 32'd1);
    check_val("rst_in_write_cnt", 32'(we_cnt), 32'd0);
    check_val("rst_in_write_csr", mem[1], 32'h0000_0011);

    for (int i = 0; i < 4; i++) preload(i, $urandom);
    for (int t = 0; t < 40; t++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_txn(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), wd,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
